uart_rx_engine: RTL

Parametrised next-generation UART receive engine for the DWBUART peripheral: synchroniser, fractional baud accumulator at 16x oversampling, 3-sample majority vote, and a frame state machine.
- Data length: 5..MAX_DATA_BITS; parity: none/even/odd; stop bits: 1 or 2.
- Adds break detection and a valid/ready output handshake with overrun reporting.
- Sits between the uart_rx_i pin and the RX FIFO/register block.

---
 rtl/uart_pkg.sv | 57 +++++
 rtl/uart_rx_engine_if.sv | 44 ++++
 rtl/rx_sampler.sv | 96 +++++++++
 rtl/uart_rx_engine.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive engine.
// Contents:
//   rx_state_t  - frame state machine states
//   parity_t    - parity mode encodings as they appear on cr_p_i
//   OVERSAMPLE, SAMPLE_POINT_A/B/C - oversample ticks per bit and the
//                 three tick counts at which the line is sampled
//   ds_to_len() - decode of the cr_ds_i data-size field into a bit count
//   decode_parity() - decode of cr_p_i into a parity_t
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        DONE
    } rx_state_t;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'b00,
        PARITY_EVEN = 2'b10,
        PARITY_ODD  = 2'b11
    } parity_t;

    localparam int OVERSAMPLE     = 16;
    localparam int SAMPLE_POINT_A = 7;
    localparam int SAMPLE_POINT_B = 8;
    localparam int SAMPLE_POINT_C = 9;

    // The largest size code selects the widest frame the instance was built for.
    function automatic logic [3:0] ds_to_len(input logic [1:0] ds, input int max_bits);
        logic [3:0] len;
        case (ds)
            2'b00:   len = 4'd5;
            2'b01:   len = 4'd6;
            2'b10:   len = 4'd7;
            default: len = 4'(max_bits);
        endcase
        return len;
    endfunction

    // Bit 1 enables parity; bit 0 then selects odd over even.
    function automatic parity_t decode_parity(input logic [1:0] p);
        parity_t mode;
        if (!p[1]) begin
            mode = PARITY_NONE;
        end else if (p[0]) begin
            mode = PARITY_ODD;
        end else begin
            mode = PARITY_EVEN;
        end
        return mode;
    endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Output handshake between the receive engine and its consumer
// (RX FIFO / register block).
// Signals:
//   data_o          received data, right-aligned, unused upper bits 0
//   parity_err_o    parity mismatch for data_o
//   frame_err_o     a stop bit was sampled 0
//   break_o         data, parity and first stop all sampled 0
//   output_valid_o  data_o and the flags are valid
//   overrun_o       one-cycle pulse when a completed frame is dropped
//   output_ready_i  consumer accepts the presented frame
// Modports: master = receive engine, slave = consumer.
interface uart_rx_engine_if #(
    parameter int MAX_DATA_BITS = 8
);

    logic [MAX_DATA_BITS-1:0] data_o;
    logic                     parity_err_o;
    logic                     frame_err_o;
    logic                     break_o;
    logic                     output_valid_o;
    logic                     overrun_o;
    logic                     output_ready_i;

    modport master (
        output data_o,
        output parity_err_o,
        output frame_err_o,
        output break_o,
        output output_valid_o,
        output overrun_o,
        input  output_ready_i
    );

    modport slave (
        input  data_o,
        input  parity_err_o,
        input  frame_err_o,
        input  break_o,
        input  output_valid_o,
        input  overrun_o,
        output output_ready_i
    );

endinterface

// File: rtl/rx_sampler.sv
// Line front end for the UART receiver: input synchroniser, falling-edge
// detect, fractional baud phase accumulator, 0..15 oversample tick counter
// and 3-sample majority vote.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-low reset
//   uart_rx_i     raw serial input (idle high)
//   clear         restart bit timing (accumulator and tick counter to 0)
//   acc_incr      phase increment; each carry out is one oversample tick
//   rx_sync       synchronised line level
//   fall_edge     synchronised 1->0 transition
//   bit_valid     strobe at tick count 9, when bit_val is the voted bit
//   bit_val       majority of the samples taken at counts 7, 8 and 9
//   bit_end       strobe at tick count 15, the end of the bit period
module rx_sampler
    import uart_pkg::*;
#(
    parameter int ACC_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 uart_rx_i,
    input  logic                 clear,
    input  logic [ACC_WIDTH-1:0] acc_incr,
    output logic                 rx_sync,
    output logic                 fall_edge,
    output logic                 bit_valid,
    output logic                 bit_val,
    output logic                 bit_end
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH:0]     acc_sum;
    logic                   tick;
    logic [3:0]             tick_cnt;
    logic                   samp_a;
    logic                   samp_b;

    assign rx_sync   = sync_q[SYNC_STAGES-1];
    assign fall_edge = rx_prev & ~rx_sync;

    // One extra bit on the sum captures the carry, which is the tick.
    assign acc_sum = {1'b0, acc} + {1'b0, acc_incr};
    assign tick    = acc_sum[ACC_WIDTH];

    // The synchroniser and edge history reset to the idle-high level so a
    // reset release never looks like a start edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
            rx_prev <= rx_sync;
        end
    end

    // Bit timing restarts on each start edge so every frame is centred on its
    // own start bit rather than on a free-running phase.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc      <= '0;
            tick_cnt <= '0;
        end else if (clear) begin
            acc      <= '0;
            tick_cnt <= '0;
        end else begin
            acc <= acc_sum[ACC_WIDTH-1:0];
            if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
        end
    end

    // The first two votes are held; the third is the live level at count 9.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (tick) begin
            if (tick_cnt == 4'(SAMPLE_POINT_A)) begin
                samp_a <= rx_sync;
            end
            if (tick_cnt == 4'(SAMPLE_POINT_B)) begin
                samp_b <= rx_sync;
            end
        end
    end

    assign bit_valid = tick && (tick_cnt == 4'(SAMPLE_POINT_C));
    assign bit_val   = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
    assign bit_end   = tick && (tick_cnt == 4'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: frames the voted bit stream from rx_sampler into
// 5..MAX_DATA_BITS data bits with optional parity and one or two stop bits,
// reports parity/frame/break errors and presents each frame on a
// valid/ready handshake, pulsing overrun when a frame cannot be delivered.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-low reset
//   cr_acc_incr_i  baud accumulator increment (16 ticks per bit)
//   cr_ds_i        data size code, latched at the start edge
//   cr_p_i         parity mode, latched at the start edge
//   cr_s_i         stop bits (0 = one, 1 = two), latched at the start edge
//   uart_rx_i      serial input, idle high
//   rx_if          output handshake (master side)
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 8,
    parameter int ACC_WIDTH     = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ACC_WIDTH-1:0] cr_acc_incr_i,
    input  logic [1:0]           cr_ds_i,
    input  logic [1:0]           cr_p_i,
    input  logic                 cr_s_i,
    input  logic                 uart_rx_i,
    uart_rx_engine_if.master     rx_if
);

    localparam int IDX_W = (MAX_DATA_BITS > 8) ? 4 : 3;

    rx_state_t                state;
    logic [3:0]               frame_len;
    parity_t                  par_mode;
    logic                     two_stop;
    logic [IDX_W-1:0]         bit_idx;
    logic [MAX_DATA_BITS-1:0] data_sr;
    logic                     par_bit;
    logic                     stop1_bit;
    logic                     stop2_bit;

    logic rx_sync;
    logic fall_edge;
    logic bit_valid;
    logic bit_val;
    logic bit_end;
    logic start_frame;
    logic last_data_bit;
    logic parity_err_c;
    logic frame_err_c;
    logic break_c;
    logic accept;

    // A start is a fresh falling edge seen while idle; after a break the line
    // stays low, so no edge exists until it has returned high first.
    assign start_frame   = (state == IDLE) && fall_edge && !rx_sync;
    assign last_data_bit = (bit_idx == IDX_W'(frame_len - 4'd1));
    assign accept        = !rx_if.output_valid_o || rx_if.output_ready_i;

    rx_sampler #(
        .ACC_WIDTH   (ACC_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .uart_rx_i (uart_rx_i),
        .clear     (start_frame),
        .acc_incr  (cr_acc_incr_i),
        .rx_sync   (rx_sync),
        .fall_edge (fall_edge),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .bit_end   (bit_end)
    );

    // Frame status, evaluated from the captured bits while in DONE.
    always_comb begin
        parity_err_c = 1'b0;
        case (par_mode)
            PARITY_EVEN: parity_err_c = (^data_sr) ^ par_bit;
            PARITY_ODD:  parity_err_c = ~((^data_sr) ^ par_bit);
            default:     parity_err_c = 1'b0;
        endcase
        frame_err_c = !stop1_bit || (two_stop && !stop2_bit);
        break_c     = (data_sr == '0) && ((par_mode == PARITY_NONE) || !par_bit) && !stop1_bit;
    end

    // Frame state machine and registered handshake outputs. Stop bits finish
    // at mid-bit so the next start edge is never missed on back-to-back
    // frames. A DONE load overrides the valid clear from a same-cycle
    // handshake; a frame arriving while the old one is still unaccepted is
    // dropped with an overrun pulse and the old frame is kept stable.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state                <= IDLE;
            frame_len            <= 4'd5;
            par_mode             <= PARITY_NONE;
            two_stop             <= 1'b0;
            bit_idx              <= '0;
            data_sr              <= '0;
            par_bit              <= 1'b0;
            stop1_bit            <= 1'b1;
            stop2_bit            <= 1'b1;
            rx_if.data_o         <= '0;
            rx_if.parity_err_o   <= 1'b0;
            rx_if.frame_err_o    <= 1'b0;
            rx_if.break_o        <= 1'b0;
            rx_if.output_valid_o <= 1'b0;
            rx_if.overrun_o      <= 1'b0;
        end else begin
            rx_if.overrun_o <= 1'b0;
            if (rx_if.output_valid_o && rx_if.output_ready_i) begin
                rx_if.output_valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_frame) begin
                        frame_len <= ds_to_len(cr_ds_i, MAX_DATA_BITS);
                        par_mode  <= decode_parity(cr_p_i);
                        two_stop  <= cr_s_i;
                        bit_idx   <= '0;
                        data_sr   <= '0;
                        par_bit   <= 1'b0;
                        stop1_bit <= 1'b1;
                        stop2_bit <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_valid && bit_val) begin
                        state <= IDLE;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_valid) begin
                        data_sr[bit_idx] <= bit_val;
                    end
                    if (bit_end) begin
                        if (last_data_bit) begin
                            state <= (par_mode == PARITY_NONE) ? STOP1 : PARITY;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_valid) begin
                        par_bit <= bit_val;
                    end
                    if (bit_end) begin
                        state <= STOP1;
                    end
                end
                STOP1: begin
                    if (bit_valid) begin
                        stop1_bit <= bit_val;
                        if (!two_stop) begin
                            state <= DONE;
                        end
                    end else if (bit_end && two_stop) begin
                        state <= STOP2;
                    end
                end
                STOP2: begin
                    if (bit_valid) begin
                        stop2_bit <= bit_val;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (accept) begin
                        rx_if.data_o         <= data_sr;
                        rx_if.parity_err_o   <= parity_err_c;
                        rx_if.frame_err_o    <= frame_err_c;
                        rx_if.break_o        <= break_c;
                        rx_if.output_valid_o <= 1'b1;
                    end else begin
                        rx_if.overrun_o <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
